// File: rtl/dma_mem_arbiter_pkg.sv
// Shared types for the DMA/CPU memory arbiter.
// Channel FSM encodings, master indices and grant helper.
package dma_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } ch_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 5;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dma_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; pointer favours the master
// that did not finish the previous burst.
module rr_arb2
    import dma_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       owner,
    output logic [1:0] gnt
);

    logic ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= M0;
        end else if (done) begin
            ptr <= ~owner;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = onehot2(ptr);
        end
    end

endmodule

// File: rtl/dma_mem_arbiter.sv
// Arbitrates CPU (m0) and DMA (m1) onto one memory port with
// independent read and write channels.
module dma_mem_arbiter
    import dma_mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     m0_rd_req_addr,
    input  logic [LEN_W-1:0]      m0_rd_req_len,
    input  logic                  m0_rd_req_valid,
    output logic                  m0_rd_req_ready,
    output logic [DATA_WIDTH-1:0] m0_rd_rdata,
    output logic                  m0_rd_last,
    output logic                  m0_rd_valid,
    input  logic                  m0_rd_ready,
    input  logic [ADDR_W-1:0]     m0_wr_req_addr,
    input  logic [LEN_W-1:0]      m0_wr_req_len,
    input  logic                  m0_wr_req_valid,
    output logic                  m0_wr_req_ready,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    input  logic                  m0_wr_valid,
    input  logic                  m0_wr_last,
    output logic                  m0_wr_ready,
    input  logic [ADDR_W-1:0]     m1_rd_req_addr,
    input  logic [LEN_W-1:0]      m1_rd_req_len,
    input  logic                  m1_rd_req_valid,
    output logic                  m1_rd_req_ready,
    output logic [DATA_WIDTH-1:0] m1_rd_rdata,
    output logic                  m1_rd_last,
    output logic                  m1_rd_valid,
    input  logic                  m1_rd_ready,
    input  logic [ADDR_W-1:0]     m1_wr_req_addr,
    input  logic [LEN_W-1:0]      m1_wr_req_len,
    input  logic                  m1_wr_req_valid,
    output logic                  m1_wr_req_ready,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    input  logic                  m1_wr_valid,
    input  logic                  m1_wr_last,
    output logic                  m1_wr_ready,
    output logic [ADDR_W-1:0]     mem_rd_req_addr,
    output logic [LEN_W-1:0]      mem_rd_req_len,
    output logic                  mem_rd_req_valid,
    input  logic                  mem_rd_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_rd_rdata,
    input  logic                  mem_rd_last,
    input  logic                  mem_rd_valid,
    output logic                  mem_rd_ready,
    output logic [ADDR_W-1:0]     mem_wr_req_addr,
    output logic [LEN_W-1:0]      mem_wr_req_len,
    output logic                  mem_wr_req_valid,
    input  logic                  mem_wr_req_ready,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_valid,
    output logic                  mem_wr_last,
    input  logic                  mem_wr_ready,
    output logic [1:0]            rd_grant,
    output logic [1:0]            wr_grant,
    output logic                  err
);

    ch_state_t rd_state, rd_next, wr_state, wr_next;

    logic [1:0]       rd_req, wr_req, rd_gnt, wr_gnt;
    logic             rd_own, wr_own, rd_in_req, wr_in_req, rd_in_data, wr_in_data;
    logic             rd_hs, wr_hs, rd_beat, wr_beat, rd_done, wr_done, rd_bad, wr_bad;
    logic [LEN_W-1:0] rd_len, rd_cnt, wr_len, wr_cnt;

    assign rd_req     = {m1_rd_req_valid, m0_rd_req_valid};
    assign wr_req     = {m1_wr_req_valid, m0_wr_req_valid};
    assign rd_own     = rd_grant[1];
    assign wr_own     = wr_grant[1];
    assign rd_in_req  = (rd_state == REQ);
    assign wr_in_req  = (wr_state == REQ);
    assign rd_in_data = (rd_state == DATA);
    assign wr_in_data = (wr_state == DATA);

    // Read channel routing
    assign mem_rd_req_addr  = rd_own ? m1_rd_req_addr : m0_rd_req_addr;
    assign mem_rd_req_len   = rd_own ? m1_rd_req_len : m0_rd_req_len;
    assign mem_rd_req_valid = rd_in_req & (rd_own ? m1_rd_req_valid : m0_rd_req_valid);
    assign m0_rd_req_ready  = rd_in_req & ~rd_own & mem_rd_req_ready;
    assign m1_rd_req_ready  = rd_in_req & rd_own & mem_rd_req_ready;
    assign mem_rd_ready     = rd_in_data & (rd_own ? m1_rd_ready : m0_rd_ready);
    assign m0_rd_valid      = rd_in_data & ~rd_own & mem_rd_valid;
    assign m1_rd_valid      = rd_in_data & rd_own & mem_rd_valid;
    assign m0_rd_last       = rd_in_data & ~rd_own & mem_rd_last;
    assign m1_rd_last       = rd_in_data & rd_own & mem_rd_last;
    assign m0_rd_rdata      = (rd_in_data & ~rd_own) ? mem_rd_rdata : '0;
    assign m1_rd_rdata      = (rd_in_data & rd_own) ? mem_rd_rdata : '0;

    // Write channel routing
    assign mem_wr_req_addr  = wr_own ? m1_wr_req_addr : m0_wr_req_addr;
    assign mem_wr_req_len   = wr_own ? m1_wr_req_len : m0_wr_req_len;
    assign mem_wr_req_valid = wr_in_req & (wr_own ? m1_wr_req_valid : m0_wr_req_valid);
    assign m0_wr_req_ready  = wr_in_req & ~wr_own & mem_wr_req_ready;
    assign m1_wr_req_ready  = wr_in_req & wr_own & mem_wr_req_ready;
    assign mem_wr_data      = wr_own ? m1_wr_data : m0_wr_data;
    assign mem_wr_valid     = wr_in_data & (wr_own ? m1_wr_valid : m0_wr_valid);
    assign mem_wr_last      = wr_in_data & (wr_own ? m1_wr_last : m0_wr_last);
    assign m0_wr_ready      = wr_in_data & ~wr_own & mem_wr_ready;
    assign m1_wr_ready      = wr_in_data & wr_own & mem_wr_ready;

    assign rd_hs   = mem_rd_req_valid & mem_rd_req_ready;
    assign wr_hs   = mem_wr_req_valid & mem_wr_req_ready;
    assign rd_beat = mem_rd_valid & mem_rd_ready;
    assign wr_beat = mem_wr_valid & mem_wr_ready;
    assign rd_done = rd_beat & mem_rd_last;
    assign wr_done = wr_beat & mem_wr_last;

    // A burst is len+1 beats; last must land exactly on count len
    assign rd_bad = rd_beat & (mem_rd_last ? (rd_cnt != rd_len) : (rd_cnt == rd_len));
    assign wr_bad = wr_beat & (mem_wr_last ? (wr_cnt != wr_len) : (wr_cnt == wr_len));

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_req),
        .done  (rd_done),
        .owner (rd_own),
        .gnt   (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_req),
        .done  (wr_done),
        .owner (wr_own),
        .gnt   (wr_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= IDLE;
            wr_state <= IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        wr_next = wr_state;
        case (rd_state)
            IDLE:    if (|rd_req) rd_next = REQ;
            REQ:     if (rd_hs) rd_next = DATA;
            DATA:    if (rd_done) rd_next = IDLE;
            default: rd_next = IDLE;
        endcase
        case (wr_state)
            IDLE:    if (|wr_req) wr_next = REQ;
            REQ:     if (wr_hs) wr_next = DATA;
            DATA:    if (wr_done) wr_next = IDLE;
            default: wr_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_grant <= '0;
            wr_grant <= '0;
            rd_len   <= '0;
            wr_len   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            if (rd_state == IDLE) rd_grant <= rd_gnt;
            else if (rd_done)     rd_grant <= '0;
            if (wr_state == IDLE) wr_grant <= wr_gnt;
            else if (wr_done)     wr_grant <= '0;
            if (rd_hs) begin
                rd_len <= mem_rd_req_len;
                rd_cnt <= '0;
            end else if (rd_beat) begin
                rd_cnt <= rd_cnt + 5'd1;
            end
            if (wr_hs) begin
                wr_len <= mem_wr_req_len;
                wr_cnt <= '0;
            end else if (wr_beat) begin
                wr_cnt <= wr_cnt + 5'd1;
            end
            err <= err | rd_bad | wr_bad;
        end
    end

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Self-checking bench for dma_mem_arbiter: vector table of single
// bursts plus hand sequences for arbitration, errors and reset.
module tb_dma_mem_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0][31:0]   rd_req_addr, wr_req_addr;
    logic [1:0][4:0]    rd_req_len, wr_req_len;
    logic [1:0]         rd_req_valid, wr_req_valid, rd_ready, wr_valid, wr_last;
    logic [1:0][DW-1:0] wr_data;
    wire  [1:0]         rd_req_ready, rd_valid, rd_last, wr_req_ready, wr_ready;
    wire  [1:0][DW-1:0] rd_rdata;

    wire  [31:0]   mem_rd_req_addr, mem_wr_req_addr;
    wire  [4:0]    mem_rd_req_len, mem_wr_req_len;
    wire           mem_rd_req_valid, mem_wr_req_valid, mem_rd_ready;
    logic          mem_rd_req_ready, mem_wr_req_ready, mem_rd_last, mem_rd_valid, mem_wr_ready;
    logic [DW-1:0] mem_rd_rdata;
    wire  [DW-1:0] mem_wr_data;
    wire           mem_wr_valid, mem_wr_last;
    wire  [1:0]    rd_grant, wr_grant;
    wire           err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] wr_q[$];

    typedef struct {
        bit         wr;
        bit         m;
        logic [31:0] addr;
        logic [4:0] len;
        logic [1:0] eg;
        int         nb;
    } vec_t;

    vec_t vecs [6];

    dma_mem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_rd_req_addr   (rd_req_addr[0]),
        .m0_rd_req_len    (rd_req_len[0]),
        .m0_rd_req_valid  (rd_req_valid[0]),
        .m0_rd_req_ready  (rd_req_ready[0]),
        .m0_rd_rdata      (rd_rdata[0]),
        .m0_rd_last       (rd_last[0]),
        .m0_rd_valid      (rd_valid[0]),
        .m0_rd_ready      (rd_ready[0]),
        .m0_wr_req_addr   (wr_req_addr[0]),
        .m0_wr_req_len    (wr_req_len[0]),
        .m0_wr_req_valid  (wr_req_valid[0]),
        .m0_wr_req_ready  (wr_req_ready[0]),
        .m0_wr_data       (wr_data[0]),
        .m0_wr_valid      (wr_valid[0]),
        .m0_wr_last       (wr_last[0]),
        .m0_wr_ready      (wr_ready[0]),
        .m1_rd_req_addr   (rd_req_addr[1]),
        .m1_rd_req_len    (rd_req_len[1]),
        .m1_rd_req_valid  (rd_req_valid[1]),
        .m1_rd_req_ready  (rd_req_ready[1]),
        .m1_rd_rdata      (rd_rdata[1]),
        .m1_rd_last       (rd_last[1]),
        .m1_rd_valid      (rd_valid[1]),
        .m1_rd_ready      (rd_ready[1]),
        .m1_wr_req_addr   (wr_req_addr[1]),
        .m1_wr_req_len    (wr_req_len[1]),
        .m1_wr_req_valid  (wr_req_valid[1]),
        .m1_wr_req_ready  (wr_req_ready[1]),
        .m1_wr_data       (wr_data[1]),
        .m1_wr_valid      (wr_valid[1]),
        .m1_wr_last       (wr_last[1]),
        .m1_wr_ready      (wr_ready[1]),
        .mem_rd_req_addr  (mem_rd_req_addr),
        .mem_rd_req_len   (mem_rd_req_len),
        .mem_rd_req_valid (mem_rd_req_valid),
        .mem_rd_req_ready (mem_rd_req_ready),
        .mem_rd_rdata     (mem_rd_rdata),
        .mem_rd_last      (mem_rd_last),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_ready     (mem_rd_ready),
        .mem_wr_req_addr  (mem_wr_req_addr),
        .mem_wr_req_len   (mem_wr_req_len),
        .mem_wr_req_valid (mem_wr_req_valid),
        .mem_wr_req_ready (mem_wr_req_ready),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_valid     (mem_wr_valid),
        .mem_wr_last      (mem_wr_last),
        .mem_wr_ready     (mem_wr_ready),
        .rd_grant         (rd_grant),
        .wr_grant         (wr_grant),
        .err              (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] gnt(input bit wr);
        return wr ? wr_grant : rd_grant;
    endfunction

    // Drives one burst on one channel from master m; starts and ends at posedge+1.
    task automatic run_burst(input bit wr, input bit m, input logic [31:0] addr,
                             input logic [4:0] len, input logic [1:0] eg, input int ew,
                             input bit tog, input int last_at, input bit ee,
                             output int beats);
        int w = 0;
        int beat = 0;
        int cyc = 0;
        bit done = 0;
        bit have = 0;
        bit o = !m;
        logic [DW-1:0] d = '0;
        logic [DW-1:0] x;
        beats = 0;
        if (wr) begin
            wr_req_addr[m] = addr; wr_req_len[m] = len; wr_req_valid[m] = 1'b1;
            mem_wr_req_ready = 1'b0;
        end else begin
            rd_req_addr[m] = addr; rd_req_len[m] = len; rd_req_valid[m] = 1'b1;
            mem_rd_req_ready = 1'b0;
        end
        @(negedge clk);
        while (gnt(wr) !== eg && w < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            w++;
        end
        chk("grant_wait", w, ew);
        chk("grant", gnt(wr), eg);
        chk("req_addr", wr ? mem_wr_req_addr : mem_rd_req_addr, addr);
        chk("req_len", wr ? mem_wr_req_len : mem_rd_req_len, len);
        chk("req_valid", wr ? mem_wr_req_valid : mem_rd_req_valid, 1);
        chk("req_ready_stall", wr ? wr_req_ready[m] : rd_req_ready[m], 0);
        @(posedge clk); #1;
        if (wr) mem_wr_req_ready = 1'b1; else mem_rd_req_ready = 1'b1;
        @(negedge clk);
        chk("req_ready_own", wr ? wr_req_ready[m] : rd_req_ready[m], 1);
        chk("req_ready_other", wr ? wr_req_ready[o] : rd_req_ready[o], 0);
        @(posedge clk); #1;
        if (wr) begin
            wr_req_valid[m] = 1'b0; mem_wr_req_ready = 1'b0;
        end else begin
            rd_req_valid[m] = 1'b0; mem_rd_req_ready = 1'b0;
            rd_ready[m] = 1'b1; rd_ready[o] = 1'b0;
        end
        while (!done && cyc < 100) begin
            if (wr) begin
                mem_wr_ready = tog ? (cyc % 2 == 1) : 1'b1;
                if (!have) begin
                    d = $urandom; wr_q.push_back(d); have = 1;
                end
                wr_data[m] = d; wr_valid[m] = 1'b1; wr_last[m] = (beat == last_at);
            end else begin
                mem_rd_valid = tog ? (cyc % 2 == 0) : 1'b1;
                d = $urandom;
                mem_rd_rdata = d;
                mem_rd_last = mem_rd_valid && (beat == last_at);
                if (mem_rd_valid) rd_q.push_back(d);
            end
            @(negedge clk);
            chk("grant_data", gnt(wr), eg);
            if (wr) begin
                chk("mem_wr_valid", mem_wr_valid, 1);
                chk("wr_ready_own", wr_ready[m], mem_wr_ready);
                chk("wr_ready_other", wr_ready[o], 0);
                if (mem_wr_valid && mem_wr_ready) begin
                    x = (wr_q.size() > 0) ? wr_q.pop_front() : ~mem_wr_data;
                    chk("wr_data", mem_wr_data, x);
                    chk("wr_last", mem_wr_last, beat == last_at);
                    beats++;
                end
            end else begin
                chk("rd_valid_own", rd_valid[m], mem_rd_valid);
                chk("rd_valid_other", rd_valid[o], 0);
                chk("mem_rd_ready", mem_rd_ready, 1);
                if (rd_valid[m] && rd_ready[m]) begin
                    x = (rd_q.size() > 0) ? rd_q.pop_front() : ~rd_rdata[m];
                    chk("rd_data", rd_rdata[m], x);
                    chk("rd_last", rd_last[m], beat == last_at);
                    beats++;
                end
            end
            @(posedge clk); #1;
            if (wr ? mem_wr_ready : mem_rd_valid) begin
                done = (beat == last_at);
                beat++;
                have = 0;
            end
            cyc++;
        end
        chk("burst_done", done, 1);
        if (wr) begin
            wr_valid[m] = 1'b0; wr_last[m] = 1'b0; mem_wr_ready = 1'b0;
        end else begin
            mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
        end
        @(negedge clk);
        chk("idle_grant", gnt(wr), 0);
        chk("err", err, ee);
        chk("idle_mem_valid", wr ? mem_wr_valid : mem_rd_ready, 0);
        chk("queue_empty", wr ? wr_q.size() : rd_q.size(), 0);
        if (wr) wr_q.delete(); else rd_q.delete();
        @(posedge clk); #1;
    endtask

    int b0, b1, w;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 5'd7,  2'b10, 8};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 5'd7,  2'b01, 8};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 5'd0,  2'b01, 1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0080, 5'd31, 2'b10, 32};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 5'd3,  2'b01, 4};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 5'd2,  2'b10, 3};

        rd_req_addr = '0; wr_req_addr = '0; rd_req_len = '0; wr_req_len = '0;
        rd_req_valid = '0; wr_req_valid = '0; rd_ready = '0;
        wr_valid = '0; wr_last = '0; wr_data = '0;
        mem_rd_req_ready = 0; mem_wr_req_ready = 0; mem_rd_last = 0;
        mem_rd_valid = 0; mem_wr_ready = 0; mem_rd_rdata = '0;

        // Reset state, with a request pending that must be ignored
        rd_req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_grant", rd_grant, 0);
        chk("rst_wr_grant", wr_grant, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_rd_req_valid", mem_rd_req_valid, 0);
        chk("rst_mem_wr_valid", mem_wr_valid, 0);
        chk("rst_rd_req_ready", rd_req_ready, 0);
        rd_req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Simultaneous read requests: m0 first, m1 after one idle cycle
        rd_req_addr[1] = 32'h180; rd_req_len[1] = 5'd3; rd_req_valid[1] = 1'b1;
        fork
            run_burst(0, 0, 32'h80, 5'd3, 2'b01, 1, 0, 3, 0, b0);
            begin
                repeat (4) @(posedge clk);
                #2 rd_req_valid[0] = 1'b1;
            end
        join
        chk("rr_m0_beats", b0, 4);
        run_burst(0, 1, 32'h180, 5'd3, 2'b10, 0, 0, 3, 0, b1);
        chk("rr_m1_beats", b1, 4);
        run_burst(0, 0, 32'h80, 5'd3, 2'b01, 0, 0, 3, 0, b0);
        chk("rr_m0_again_beats", b0, 4);

        foreach (vecs[i]) begin
            run_burst(vecs[i].wr, vecs[i].m, vecs[i].addr, vecs[i].len,
                      vecs[i].eg, 1, 0, int'(vecs[i].len), 0, b0);
            chk("vec_beats", b0, vecs[i].nb);
        end

        // m1 write with memory ready toggling every cycle
        run_burst(1, 1, 32'h900, 5'd7, 2'b10, 1, 1, 7, 0, b0);
        chk("toggle_beats", b0, 8);

        // Concurrent m0 write and m1 read
        fork
            run_burst(1, 0, 32'h500, 5'd7, 2'b01, 1, 0, 7, 0, b0);
            run_burst(0, 1, 32'h600, 5'd7, 2'b10, 1, 0, 7, 0, b1);
            begin
                repeat (5) @(negedge clk);
                chk("both_active", {wr_grant, rd_grant}, 4'b0110);
            end
        join
        chk("conc_wr_beats", b0, 8);
        chk("conc_rd_beats", b1, 8);

        // Early last on beat 5 of a len 7 read sets sticky err
        run_burst(0, 0, 32'hA00, 5'd7, 2'b01, 1, 0, 4, 1, b0);
        chk("early_last_beats", b0, 5);
        run_burst(0, 1, 32'hB00, 5'd3, 2'b10, 1, 0, 3, 1, b1);
        chk("sticky_beats", b1, 4);

        // Reset asserted during write beat 3
        wr_req_addr[0] = 32'h700; wr_req_len[0] = 5'd7; wr_req_valid[0] = 1'b1;
        mem_wr_req_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!mem_wr_req_valid && w < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            w++;
        end
        chk("rst_seq_req", mem_wr_req_valid, 1);
        @(posedge clk); #1;
        wr_req_valid[0] = 1'b0; mem_wr_req_ready = 1'b0;
        mem_wr_ready = 1'b1; wr_valid[0] = 1'b1; wr_data[0] = 32'h1234_5678;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("beat3_valid", mem_wr_valid, 1);
        chk("beat3_grant", wr_grant, 2'b01);
        #1 rst = 1'b0;
        #1;
        chk("async_wr_grant", wr_grant, 0);
        chk("async_mem_wr_valid", mem_wr_valid, 0);
        chk("async_wr_ready", wr_ready[0], 0);
        chk("async_err_clear", err, 0);
        wr_valid[0] = 1'b0; mem_wr_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", wr_grant, 0);
        @(posedge clk); #1;

        // Pointer back at m0 after reset
        wr_req_addr[1] = 32'hC00; wr_req_len[1] = 5'd2; wr_req_valid[1] = 1'b1;
        run_burst(1, 0, 32'hD00, 5'd1, 2'b01, 1, 0, 1, 0, b0);
        chk("post_rst_m0_beats", b0, 2);
        run_burst(1, 1, 32'hC00, 5'd2, 2'b10, 0, 0, 2, 0, b1);
        chk("post_rst_m1_beats", b1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
